// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the cache-to-SRAM bridge: FSM encoding,
// default data-memory base address and SRAM geometry.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_BASE_ADDR = 1024;
    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;

    // A read moves one 64-bit block, a write one 32-bit word, in halfword beats.
    localparam int unsigned READ_BEATS  = 4;
    localparam int unsigned WRITE_BEATS = 2;
    localparam int unsigned BEAT_W      = 2;

    function automatic logic [BEAT_W-1:0] last_beat(input state_t st);
        return (st == READ) ? BEAT_W'(READ_BEATS - 1) : BEAT_W'(WRITE_BEATS - 1);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Request/response bus between the data-cache controller (master) and the
// SRAM controller (slave).
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [63:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Bridges 32-bit writes / 64-bit block reads from the cache onto a 16-bit
// asynchronous SRAM, one halfword beat of BEAT_CYCLES clocks at a time.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned BEAT_CYCLES = 2,
    parameter int unsigned ADDR_W      = SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int unsigned     CYC_W    = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BEAT_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [BEAT_W-1:0]      beat;
    logic [CYC_W-1:0]       cyc;
    logic [ADDR_W-1:0]      base_addr;
    logic [31:0]            wdata;
    logic [63:0]            rdata;

    logic [31:0]            off;
    logic [ADDR_W-1:0]      rd_base;
    logic [ADDR_W-1:0]      wr_base;
    logic                   last_cyc;
    logic                   dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;

    // Upper offset bits are dropped so out-of-range addresses alias into the SRAM.
    assign off     = bus.address - BASE_ADDR;
    assign rd_base = {off[ADDR_W:3], 2'b00};
    assign wr_base = {off[ADDR_W:2], 1'b0};
    wire   unused_off = ^{off[31:ADDR_W+1], off[1:0]};

    assign last_cyc = (cyc == LAST_CYC);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.wr_en)      state_next = WRITE;
                else if (bus.rd_en) state_next = READ;
            end
            READ, WRITE: begin
                if (last_cyc && (beat == last_beat(state))) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: read_data is an ordinary register bank, so it is cleared by reset
    // like any other state; the requester relies on it reading 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            cyc       <= '0;
            base_addr <= '0;
            wdata     <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    cyc  <= '0;
                    if (bus.wr_en) begin
                        base_addr <= wr_base;
                        wdata     <= bus.write_data;
                    end else if (bus.rd_en) begin
                        base_addr <= rd_base;
                    end
                end
                READ, WRITE: begin
                    if (last_cyc) begin
                        cyc  <= '0;
                        beat <= beat + BEAT_W'(1);
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                    // Sample on the last beat cycle so the SRAM has had the full beat to settle.
                    if (state == READ && last_cyc) rdata[{beat, 4'b0000} +: 16] <= SRAM_DQ;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            READ: begin
                SRAM_ADDR = base_addr + ADDR_W'(beat);
            end
            WRITE: begin
                SRAM_ADDR = base_addr + ADDR_W'(beat);
                // WE_N rises one cycle before the beat ends, with address and data still held.
                SRAM_WE_N = last_cyc;
                dq_oe     = 1'b1;
                dq_out    = beat[0] ? wdata[31:16] : wdata[15:0];
            end
            default: ;
        endcase
    end

    assign SRAM_DQ = dq_oe ? dq_out : 'z;

    assign bus.ready     = (state == DONE) || (state == IDLE && !bus.rd_en && !bus.wr_en);
    assign bus.read_data = rdata;

    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
